// File: rtl/ift_stim_sequencer.sv
// ----------------------------------------------------------------------------
// ift_stim_sequencer
//
// Purpose:
//   Holds a table of stimulus records {a, b, a_t, b_t, dur} and plays them into
//   an IFT-instrumented DUT. Each record is held for max(dur, 1) cycles. While
//   playing, the DUT taint output c_t is OR-accumulated and the index of the
//   first record that produced nonzero taint is captured.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_we/addr/wdata   record write port, accepted only when not playing
//   num_entries         number of records to play, sampled on start
//   start, abort        begin playback / stop playback (abort has priority)
//   a, b, a_t, b_t      registered drive into the DUT, 0 when not playing
//   c_t                 DUT taint output being monitored
//   busy, done          playing / one-cycle completion pulse
//   entry_idx           record currently driven
//   c_t_acc             OR of c_t over all played cycles
//   first_taint_vld/idx first played cycle with c_t != 0 and its record index
// ----------------------------------------------------------------------------
module ift_stim_sequencer #(
   parameter int DEPTH   = 18,
   parameter int TAINT_W = 32,
   parameter int DUR_W   = 16,
   parameter int IDX_W   = $clog2(DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cfg_we,
   input  logic [IDX_W-1:0]                 cfg_addr,
   input  logic [2+2*TAINT_W+DUR_W-1:0]     cfg_wdata,
   input  logic [IDX_W:0]                   num_entries,
   input  logic                             start,
   input  logic                             abort,
   output logic                             a,
   output logic                             b,
   output logic [TAINT_W-1:0]               a_t,
   output logic [TAINT_W-1:0]               b_t,
   input  logic [TAINT_W-1:0]               c_t,
   output logic                             busy,
   output logic                             done,
   output logic [IDX_W-1:0]                 entry_idx,
   output logic [TAINT_W-1:0]               c_t_acc,
   output logic                             first_taint_vld,
   output logic [IDX_W-1:0]                 first_taint_idx
);

   localparam int             REC_W   = 2 + 2*TAINT_W + DUR_W;
   localparam logic [IDX_W:0] DEPTH_N = (IDX_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     entry_q, entry_d;
   logic [IDX_W:0]       n_q, n_d;
   logic [DUR_W-1:0]     hold_q, hold_d;      // remaining hold cycles minus one
   logic                 a_q, a_d, b_q, b_d;
   logic [TAINT_W-1:0]   at_q, at_d, bt_q, bt_d;
   logic [TAINT_W-1:0]   acc_q, acc_d;
   logic                 ftv_q, ftv_d;
   logic [IDX_W-1:0]     fti_q, fti_d;

   logic [REC_W-1:0]     mem_q [DEPTH];

   logic [IDX_W-1:0]     rd_idx;
   logic [REC_W-1:0]     rd_rec;
   logic [DUR_W-1:0]     rd_dur;
   logic [DUR_W-1:0]     rd_hold;
   logic                 last_entry;

   // NOTE: the record table has no reset; its contents only matter once the
   // host has written them, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (cfg_we && state_q != PLAY && {1'b0, cfg_addr} < DEPTH_N)
         mem_q[cfg_addr] <= cfg_wdata;
   end

   // Record to load on the next transition: entry 0 on start, otherwise the
   // successor of the current entry.
   assign last_entry = ({1'b0, entry_q} == n_q - 1'b1);
   assign rd_idx     = (state_q == PLAY && !last_entry) ? entry_q + 1'b1 : '0;
   assign rd_rec     = mem_q[rd_idx];
   assign rd_dur     = rd_rec[DUR_W-1:0];
   assign rd_hold    = (rd_dur == '0) ? '0 : rd_dur - 1'b1;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         entry_q <= '0;
         n_q     <= '0;
         hold_q  <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         at_q    <= '0;
         bt_q    <= '0;
         acc_q   <= '0;
         ftv_q   <= 1'b0;
         fti_q   <= '0;
      end else begin
         state_q <= state_d;
         entry_q <= entry_d;
         n_q     <= n_d;
         hold_q  <= hold_d;
         a_q     <= a_d;
         b_q     <= b_d;
         at_q    <= at_d;
         bt_q    <= bt_d;
         acc_q   <= acc_d;
         ftv_q   <= ftv_d;
         fti_q   <= fti_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d = state_q;
      entry_d = entry_q;
      n_d     = n_q;
      hold_d  = hold_q;
      a_d     = a_q;
      b_d     = b_q;
      at_d    = at_q;
      bt_d    = bt_q;
      acc_d   = acc_q;
      ftv_d   = ftv_q;
      fti_d   = fti_q;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               acc_d = '0;
               ftv_d = 1'b0;
               fti_d = '0;
               if (num_entries != '0) begin
                  n_d     = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
                  state_d = PLAY;
                  entry_d = '0;
                  hold_d  = rd_hold;
                  {a_d, b_d, at_d, bt_d} = rd_rec[REC_W-1:DUR_W];
               end else begin
                  state_d = DONE;
               end
            end
         end

         PLAY: begin
            // Every played cycle is monitored, including the one that aborts.
            acc_d = acc_q | c_t;
            if (c_t != '0 && !ftv_q) begin
               ftv_d = 1'b1;
               fti_d = entry_q;
            end

            if (abort || (hold_q == '0 && last_entry)) begin
               state_d = abort ? IDLE : DONE;
               entry_d = '0;
               hold_d  = '0;
               a_d     = 1'b0;
               b_d     = 1'b0;
               at_d    = '0;
               bt_d    = '0;
            end else if (hold_q == '0) begin
               // Back-to-back load: no gap cycle between records.
               entry_d = entry_q + 1'b1;
               hold_d  = rd_hold;
               {a_d, b_d, at_d, bt_d} = rd_rec[REC_W-1:DUR_W];
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end

         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      busy            = (state_q == PLAY);
      done            = (state_q == DONE);
      a               = a_q;
      b               = b_q;
      a_t             = at_q;
      b_t             = bt_q;
      entry_idx       = entry_q;
      c_t_acc         = acc_q;
      first_taint_vld = ftv_q;
      first_taint_idx = fti_q;
   end

endmodule

// File: tb/tb_ift_stim_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ift_stim_sequencer
//
// Directed and randomized playback against a reference model that expands the
// record table into its expected per-cycle drive sequence. The DUT stand-in
// produces c_t = (a ? a_t : 0) | (b ? b_t : 0).
// ----------------------------------------------------------------------------
module tb_ift_stim_sequencer;

   localparam int DEPTH   = 18;
   localparam int TAINT_W = 32;
   localparam int DUR_W   = 16;
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int REC_W   = 2 + 2*TAINT_W + DUR_W;

   typedef struct packed {
      logic               a;
      logic               b;
      logic [TAINT_W-1:0] at;
      logic [TAINT_W-1:0] bt;
      logic [DUR_W-1:0]   dur;
   } rec_t;

   logic               clk;
   logic               rst_n;
   logic               cfg_we;
   logic [IDX_W-1:0]   cfg_addr;
   logic [REC_W-1:0]   cfg_wdata;
   logic [IDX_W:0]     num_entries;
   logic               start;
   logic               abort;
   logic               a, b;
   logic [TAINT_W-1:0] a_t, b_t, c_t;
   logic               busy, done;
   logic [IDX_W-1:0]   entry_idx;
   logic [TAINT_W-1:0] c_t_acc;
   logic               first_taint_vld;
   logic [IDX_W-1:0]   first_taint_idx;

   int n_chk  = 0;
   int n_pass = 0;

   rec_t tbl [DEPTH];   // model copy of what the table should hold

   ift_stim_sequencer #(
      .DEPTH(DEPTH), .TAINT_W(TAINT_W), .DUR_W(DUR_W), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .num_entries(num_entries), .start(start), .abort(abort),
      .a(a), .b(b), .a_t(a_t), .b_t(b_t), .c_t(c_t),
      .busy(busy), .done(done), .entry_idx(entry_idx),
      .c_t_acc(c_t_acc), .first_taint_vld(first_taint_vld),
      .first_taint_idx(first_taint_idx)
   );

   function automatic logic [TAINT_W-1:0] model_ct(input rec_t r);
      return (r.a ? r.at : '0) | (r.b ? r.bt : '0);
   endfunction

   rec_t drv;
   assign drv = '{a: a, b: b, at: a_t, bt: b_t, dur: '0};
   assign c_t = model_ct(drv);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit (n_pass=%0d n_chk=%0d)", n_pass, n_chk);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] drive_vec();
      return {busy, done, a, b, a_t, b_t};
   endfunction

   function automatic logic [127:0] all_vec();
      return {busy, done, a, b, a_t, b_t, entry_idx, c_t_acc, first_taint_vld, first_taint_idx};
   endfunction

   task automatic write_rec(input int addr, input rec_t r);
      cfg_we    = 1'b1;
      cfg_addr  = IDX_W'(addr);
      cfg_wdata = r;
      @(negedge clk);
      cfg_we = 1'b0;
      if (addr < DEPTH) tbl[addr] = r;
   endtask

   // Start playback of n_req records and check every cycle against the
   // expansion of the model table. With noise set, start is toggled randomly
   // while playing and must be ignored.
   task automatic play(input int n_req, input bit noise, input string tag);
      int                 n;
      int                 hold;
      rec_t               r;
      logic [TAINT_W-1:0] ct;
      logic [TAINT_W-1:0] exp_acc;
      bit                 exp_vld;
      logic [IDX_W-1:0]   exp_idx;
      n       = (n_req > DEPTH) ? DEPTH : n_req;
      exp_acc = '0;
      exp_vld = 1'b0;
      exp_idx = '0;
      num_entries = (IDX_W+1)'(n_req);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < n; k++) begin
         r    = tbl[k];
         hold = (r.dur == '0) ? 1 : int'(r.dur);
         for (int h = 0; h < hold; h++) begin
            check({tag, " play"}, {drive_vec(), entry_idx},
                  {1'b1, 1'b0, r.a, r.b, r.at, r.bt, IDX_W'(k)});
            ct = model_ct(r);
            exp_acc |= ct;
            if (ct != '0 && !exp_vld) begin
               exp_vld = 1'b1;
               exp_idx = IDX_W'(k);
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
         end
      end
      start = 1'b0;
      check({tag, " done"}, drive_vec(), {1'b0, 1'b1, 1'b0, 1'b0, {TAINT_W{1'b0}}, {TAINT_W{1'b0}}});
      @(negedge clk);
      check({tag, " idle"}, drive_vec(), '0);
      check({tag, " acc"}, c_t_acc, exp_acc);
      check({tag, " first"}, {first_taint_vld, first_taint_idx}, {exp_vld, exp_idx});
   endtask

   initial begin
      rec_t               r;
      rec_t               r0, r1;
      logic [TAINT_W-1:0] exp_acc;
      logic [IDX_W:0]     exp_first;
      int                 n_req;

      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      num_entries = '0; start = 1'b0; abort = 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] = '0;

      // Reset state
      @(negedge clk);
      check("reset", all_vec(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed IFT sequence: 6 records, dur 8, a_t = 1
      begin
         logic [1:0] ab [6];
         ab[0] = 2'b00; ab[1] = 2'b01; ab[2] = 2'b10;
         ab[3] = 2'b11; ab[4] = 2'b10; ab[5] = 2'b01;
         for (int k = 0; k < 6; k++) begin
            r = '{a: ab[k][1], b: ab[k][0], at: 32'h1, bt: 32'h0, dur: 16'd8};
            write_rec(k, r);
         end
      end
      play(6, 1'b0, "ift6");
      check("ift6 spec acc/first", {c_t_acc, first_taint_vld, first_taint_idx},
            {32'h1, 1'b1, 5'd2});

      // Durations 0, 1, 3: holds of 1, 1, 3
      write_rec(0, '{a: 1'b1, b: 1'b0, at: 32'hA, bt: 32'h0, dur: 16'd0});
      write_rec(1, '{a: 1'b0, b: 1'b1, at: 32'h0, bt: 32'hB, dur: 16'd1});
      write_rec(2, '{a: 1'b1, b: 1'b1, at: 32'hC0, bt: 32'h0D, dur: 16'd3});
      play(3, 1'b0, "dur013");

      // num_entries = 0: done next cycle, busy never rises
      play(0, 1'b0, "zero");

      // start and abort together in IDLE: nothing starts
      num_entries = 6'd3; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start+abort idle", drive_vec(), '0);

      // Abort during entry 1 of 4, with an ignored cfg write while playing
      for (int k = 0; k < 4; k++) begin
         r = '{a: (k != 0), b: k[0], at: 32'h1 << k, bt: 32'h100 << k, dur: 16'd4};
         write_rec(k, r);
      end
      r0 = tbl[0];
      r1 = tbl[1];
      num_entries = 6'd4;
      start = 1'b1;
      @(negedge clk);                       // cycle 1, entry 0
      start = 1'b0;
      repeat (4) @(negedge clk);            // cycle 5, entry 1
      cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = {REC_W{1'b1}};
      @(negedge clk);                       // cycle 6, entry 1
      cfg_we = 1'b0;
      check("abort pre", {busy, entry_idx}, {1'b1, 5'd1});
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort outputs", drive_vec(), '0);
      exp_acc   = model_ct(r0) | model_ct(r1);
      exp_first = (model_ct(r0) != '0) ? {1'b1, 5'd0} :
                  (model_ct(r1) != '0) ? {1'b1, 5'd1} : '0;
      check("abort acc", c_t_acc, exp_acc);
      check("abort first", {first_taint_vld, first_taint_idx}, exp_first);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort no done", {busy, done}, 2'b00);
      end
      play(4, 1'b0, "replay");

      // Asynchronous reset mid-playback, then replay from entry 0
      num_entries = 6'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async reset", all_vec(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      play(4, 1'b0, "post-reset");

      // Randomized tables, lengths (including > DEPTH) and start noise
      for (int round = 0; round < 4; round++) begin
         for (int k = 0; k < DEPTH; k++) begin
            r.a   = 1'($urandom);
            r.b   = 1'($urandom);
            r.at  = ($urandom_range(0, 1) == 0) ? '0 : TAINT_W'($urandom);
            r.bt  = ($urandom_range(0, 2) == 0) ? '0 : TAINT_W'($urandom);
            r.dur = DUR_W'($urandom_range(0, 4));
            write_rec(k, r);
         end
         write_rec(DEPTH + round, '{a: 1'b1, b: 1'b1, at: '1, bt: '1, dur: '1});
         n_req = $urandom_range(0, DEPTH + 3);
         play(n_req, 1'b1, "random");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ift_stim_sequencer.md
Name: ift_stim_sequencer

Overview:
- Synthesizable replacement for the bench-side readmem loop: stores a table of stimulus records {a, b, a_t, b_t, duration} and plays them into an IFT-instrumented DUT (e.g. hierarchy), holding each record for its duration.
- Also monitors the DUT taint output c_t: accumulates it, reports the first record index that produced nonzero taint, and flags completion.
- Sits between a config/host port and the DUT's value/taint inputs inside IFT flow test harnesses.

Parameters:
- DEPTH, 18, number of record slots.
- TAINT_W, 32, width of each taint vector (a_t, b_t, c_t).
- DUR_W, 16, width of the per-record duration field in cycles.
- IDX_W, $clog2(DEPTH), index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  record write strobe.
- cfg_addr  in  IDX_W  record slot address.
- cfg_wdata  in  2+2*TAINT_W+DUR_W  packed {a, b, a_t, b_t, dur}, MSB first.
- num_entries  in  IDX_W+1  records to play (0..DEPTH); sampled on start.
- start  in  1  begin playback.
- abort  in  1  stop playback.
- a, b  out  1 each  DUT value inputs.
- a_t, b_t  out  TAINT_W each  DUT taint inputs.
- c_t  in  TAINT_W  DUT taint output.
- busy  out  1  playback in progress.
- done  out  1  one-cycle completion pulse.
- entry_idx  out  IDX_W  record currently driven.
- c_t_acc  out  TAINT_W  bitwise OR of c_t over all played cycles.
- first_taint_vld  out  1  some cycle had c_t != 0.
- first_taint_idx  out  IDX_W  entry_idx of the first such cycle.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; hold counter and entry counter 0.
- Table memory is not reset. Contents are undefined until written.
- States:
  - IDLE: start=1 with num_entries>0 latches n=min(num_entries, DEPTH), clears c_t_acc/first_taint_*, and goes to PLAY with entry 0. start=1 with num_entries=0 goes directly to DONE.
  - PLAY: drives the current record registered. Output changes one cycle after start, or one cycle after the previous record's last cycle.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Hold length per record = max(dur, 1) cycles; dur=0 is treated as 1.
- On the last hold cycle of entry k: if k=n-1, go to DONE; else load entry k+1 with no gap cycle.
- In DONE and IDLE, a/b/a_t/b_t are driven 0.
- busy=1 exactly while in PLAY.
- c_t monitoring, every PLAY cycle:
  - c_t_acc |= c_t.
  - If c_t != 0 and first_taint_vld=0: set first_taint_vld=1 and capture first_taint_idx=entry_idx.
  - Monitoring results persist after DONE until the next start.
- cfg_we:
  - Accepted only in IDLE or DONE; ignored in PLAY.
  - Writes with cfg_addr >= DEPTH are ignored.
- start while busy: ignored.
- abort (priority over everything except reset):
  - In PLAY, the next cycle returns to IDLE with a/b/a_t/b_t=0 and busy=0. No done pulse.
  - Monitoring results are kept.
- Simultaneous start and abort in IDLE: abort wins and nothing starts.
- rst_n asserted mid-playback: immediate return to reset values.

Test Plan:
- Load 6 records mirroring the directed IFT sequence (a,b)=(0,0),(0,1),(1,0),(1,1),(1,0),(0,1), each with dur=8 and a_t=0x1, b_t=0x0; num_entries=6; start. Required: busy high for exactly 48 cycles; each record held 8 cycles; done pulses on cycle 49 after start; outputs are 0 afterward.
- DUT model with c_t = a_t when a=1. Required: c_t_acc=0x1, first_taint_vld=1, first_taint_idx=2.
- Records with dur=0, 1, 3 and num_entries=3. Required: hold lengths of 1, 1 and 3 cycles; busy spans 5 cycles.
- num_entries=0 with start. Required: done pulses the next cycle; busy never rises.
- Abort during entry 1 of 4. Required: outputs are 0 and busy=0 one cycle later; no done pulse. A cfg_we issued during PLAY leaves the table unchanged, confirmed by replay.
- rst_n pulled low mid-PLAY. Required: all outputs 0 asynchronously; a following start replays from entry 0.
